// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: arbitrates fetch and data requesters onto a single-port memory
// with a fixed 4-cycle transaction and a hardware return-address stack pointer.
module mem_access_ctrl #(
   parameter logic [7:0] STACK_TOP      = 8'hFF,
   parameter logic [7:0] STACK_LIMIT    = 8'hF0,
   parameter int         MAX_DATA_BURST = 3
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       fetch_req,
   input  logic [7:0] fetch_addr,
   output logic       fetch_done,
   output logic [7:0] fetch_data,
   input  logic       data_req,
   input  logic [1:0] data_op,
   input  logic [7:0] data_addr,
   input  logic [7:0] data_wdata,
   output logic       data_done,
   output logic [7:0] data_rdata,
   output logic       data_err,
   output logic [7:0] mem_addr,
   output logic       mem_we,
   output logic [7:0] mem_wdata,
   input  logic [7:0] mem_rdata,
   output logic [7:0] sp,
   output logic       busy
);
   localparam int BW = $clog2(MAX_DATA_BURST + 1);
   localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3;
   localparam logic [1:0] OP_RD = 2'd0, OP_WR = 2'd1, OP_PUSH = 2'd2, OP_POP = 2'd3;
   localparam logic [7:0] FULL_SP = STACK_LIMIT - 8'd1;

   logic [1:0]    state_q, state_d;
   logic [7:0]    sp_q, sp_d;
   logic [BW-1:0] burst_q, burst_d;
   logic          is_data_q, is_data_d;
   logic [1:0]    op_q, op_d;
   logic          err_q, err_d;
   logic [7:0]    mem_addr_q, mem_addr_d;
   logic          mem_we_q, mem_we_d;
   logic [7:0]    mem_wdata_q, mem_wdata_d;
   logic          fetch_done_q, fetch_done_d;
   logic          data_done_q, data_done_d;
   logic [7:0]    fetch_data_q, fetch_data_d;
   logic [7:0]    data_rdata_q, data_rdata_d;
   logic          data_err_q, data_err_d;
   logic          gnt_f, gnt_d, full, empty, req_err, fin;
   logic [7:0]    req_addr;

   always_comb begin
      gnt_f        = state_q == IDLE && fetch_req && (!data_req || burst_q == BW'(MAX_DATA_BURST));
      gnt_d        = state_q == IDLE && data_req && !gnt_f;
      full         = sp_q == FULL_SP;
      empty        = sp_q == STACK_TOP;
      req_err      = (data_op == OP_PUSH && full) || (data_op == OP_POP && empty);
      req_addr     = data_op == OP_PUSH ? sp_q : data_op == OP_POP ? sp_q + 8'd1 : data_addr;
      state_d      = (state_q == IDLE && !(gnt_f || gnt_d)) ? IDLE : state_q + 2'd1;
      burst_d      = gnt_f ? '0 : gnt_d ? (fetch_req ? burst_q + BW'(1) : '0) : burst_q;
      is_data_d    = gnt_f ? 1'b0 : gnt_d ? 1'b1 : is_data_q;
      op_d         = gnt_d ? data_op : op_q;
      err_d        = gnt_f ? 1'b0 : gnt_d ? req_err : err_q;
      mem_addr_d   = gnt_f ? fetch_addr : gnt_d ? req_addr : mem_addr_q;
      mem_wdata_d  = gnt_d ? data_wdata : mem_wdata_q;
      mem_we_d     = gnt_d && (data_op == OP_WR || (data_op == OP_PUSH && !full));
      fetch_done_d = state_q == WAIT && !is_data_q;
      data_done_d  = state_q == WAIT && is_data_q;
      fetch_data_d = fetch_done_d ? mem_rdata : fetch_data_q;
      // only successful reads/pops return memory contents; everything else reports zero
      data_rdata_d = data_done_d ? ((op_q == OP_RD || (op_q == OP_POP && !err_q)) ? mem_rdata : 8'd0)
                                 : data_rdata_q;
      data_err_d   = data_done_d && err_q;
      fin          = state_q == DONE && is_data_q && !err_q;
      sp_d         = (fin && op_q == OP_PUSH) ? sp_q - 8'd1 : (fin && op_q == OP_POP) ? sp_q + 8'd1 : sp_q;
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q      <= IDLE;
         sp_q         <= STACK_TOP;
         burst_q      <= '0;
         is_data_q    <= 1'b0;
         op_q         <= OP_RD;
         err_q        <= 1'b0;
         mem_addr_q   <= 8'd0;
         mem_we_q     <= 1'b0;
         mem_wdata_q  <= 8'd0;
         fetch_done_q <= 1'b0;
         data_done_q  <= 1'b0;
         fetch_data_q <= 8'd0;
         data_rdata_q <= 8'd0;
         data_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         sp_q         <= sp_d;
         burst_q      <= burst_d;
         is_data_q    <= is_data_d;
         op_q         <= op_d;
         err_q        <= err_d;
         mem_addr_q   <= mem_addr_d;
         mem_we_q     <= mem_we_d;
         mem_wdata_q  <= mem_wdata_d;
         fetch_done_q <= fetch_done_d;
         data_done_q  <= data_done_d;
         fetch_data_q <= fetch_data_d;
         data_rdata_q <= data_rdata_d;
         data_err_q   <= data_err_d;
      end
   end

   assign fetch_done = fetch_done_q;
   assign fetch_data = fetch_data_q;
   assign data_done  = data_done_q;
   assign data_rdata = data_rdata_q;
   assign data_err   = data_err_q;
   assign mem_addr   = mem_addr_q;
   assign mem_we     = mem_we_q;
   assign mem_wdata  = mem_wdata_q;
   assign sp         = sp_q;
   assign busy       = state_q != IDLE;
endmodule
